// File: rtl/uart_frame_link.sv
// uart_frame_link: moves an N_BYTES state word between boards as SYNC/payload/checksum frames
// over a 16x-oversampled 8N1 UART, with refresh resends, link supervision and error counting.
module uart_frame_link #(
    parameter int          N_BYTES     = 2,
    parameter int          DVSR        = 54,
    parameter int          DVSR_BIT    = 7,
    parameter int          FIFO_W      = 2,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          REFRESH_CYC = 1_000_000,
    parameter int          BYTE_TMO    = 20_000,
    parameter int          LINK_TMO    = 4_000_000,
    parameter int          ERR_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic [8*N_BYTES-1:0]   data_in,
    output logic                   tx,
    output logic [8*N_BYTES-1:0]   data_out,
    output logic                   rx_valid,
    output logic                   link_up,
    output logic                   tx_busy,
    output logic [ERR_W-1:0]       err_cnt
);
    localparam int PW  = 8 * N_BYTES;
    localparam int IW  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int RCW = $clog2(REFRESH_CYC + 1);
    localparam int BTW = $clog2(BYTE_TMO + 1);
    localparam int LTW = $clog2(LINK_TMO + 1);
    localparam int FD  = 2 ** FIFO_W;

    typedef enum logic [1:0] {T_IDLE, T_SYNC, T_DATA, T_CSUM} tstate_t;
    typedef enum logic [1:0] {R_HUNT, R_DATA, R_CSUM} rstate_t;

    logic [DVSR_BIT-1:0] baud_q;
    logic                tick;
    logic [1:0]          rx_sync_q;
    logic                rxs;
    logic                rbusy_q, rdone_q;
    logic [3:0]          rs_q, rn_q, ts_q, tn_q;
    logic [7:0]          rb_q;
    logic                tbusy_q, tx_q;
    logic [9:0]          tsh_q;
    logic [7:0]          rxf_mem [FD];
    logic [7:0]          txf_mem [FD];
    logic [FIFO_W:0]     rxf_wp_q, rxf_rp_q, txf_wp_q, txf_rp_q;
    logic                rx_empty, rd_uart, tx_full, tx_empty, tx_pop, wr_uart;
    logic [7:0]          r_data, w_data, tx_sum;

    assign tick = (baud_q == DVSR_BIT'(DVSR));
    assign rxs  = rx_sync_q[1];
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q    <= '0;
            rx_sync_q <= 2'b11;
            tx_q      <= 1'b1;
        end else begin
            baud_q    <= tick ? '0 : baud_q + 1'b1;
            rx_sync_q <= {rx_sync_q[0], rx};
            tx_q      <= tsh_q[0];
        end
    end

    // Receiver: start bit confirmed at its middle (7 ticks), then one sample per 16 ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbusy_q <= 1'b0; rdone_q <= 1'b0; rs_q <= '0; rn_q <= '0; rb_q <= '0;
        end else begin
            rdone_q <= 1'b0;
            if (!rbusy_q) begin
                if (!rxs) begin rbusy_q <= 1'b1; rs_q <= '0; rn_q <= '0; end
            end else if (tick) begin
                if (rn_q == 4'd0) begin
                    if (rs_q == 4'd7) begin rs_q <= '0; rn_q <= 4'd1; rbusy_q <= !rxs; end
                    else rs_q <= rs_q + 1'b1;
                end else if (rs_q == 4'd15) begin
                    rs_q <= '0;
                    rn_q <= rn_q + 1'b1;
                    if (rn_q == 4'd9) begin rbusy_q <= 1'b0; rdone_q <= rxs; end
                    else rb_q <= {rxs, rb_q[7:1]};
                end else rs_q <= rs_q + 1'b1;
            end
        end
    end

    // Transmitter: 10-bit frame shifted out LSB first; idles with the shifter all ones.
    assign tx_pop = !tbusy_q && !tx_empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            tbusy_q <= 1'b0; tsh_q <= '1; ts_q <= '0; tn_q <= '0;
        end else if (!tbusy_q) begin
            if (!tx_empty) begin
                tbusy_q <= 1'b1; tsh_q <= {1'b1, txf_mem[txf_rp_q[FIFO_W-1:0]], 1'b0};
                ts_q <= '0; tn_q <= '0;
            end
        end else if (tick) begin
            if (ts_q == 4'd15) begin
                ts_q  <= '0;
                tsh_q <= {1'b1, tsh_q[9:1]};
                if (tn_q == 4'd9) tbusy_q <= 1'b0;
                else tn_q <= tn_q + 1'b1;
            end else ts_q <= ts_q + 1'b1;
        end
    end

    // RX FIFO is drained every cycle, so it never holds more than one byte.
    assign rx_empty = (rxf_wp_q == rxf_rp_q);
    assign rd_uart  = !rx_empty;
    assign r_data   = rxf_mem[rxf_rp_q[FIFO_W-1:0]];
    assign tx_empty = (txf_wp_q == txf_rp_q);
    assign tx_full  = (txf_wp_q[FIFO_W] != txf_rp_q[FIFO_W]) &&
                      (txf_wp_q[FIFO_W-1:0] == txf_rp_q[FIFO_W-1:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            rxf_wp_q <= '0; rxf_rp_q <= '0; txf_wp_q <= '0; txf_rp_q <= '0;
        end else begin
            if (rdone_q) rxf_wp_q <= rxf_wp_q + 1'b1;
            if (rd_uart) rxf_rp_q <= rxf_rp_q + 1'b1;
            if (wr_uart) txf_wp_q <= txf_wp_q + 1'b1;
            if (tx_pop)  txf_rp_q <= txf_rp_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rdone_q) rxf_mem[rxf_wp_q[FIFO_W-1:0]] <= rb_q;
        if (wr_uart) txf_mem[txf_wp_q[FIFO_W-1:0]] <= w_data;
    end

    tstate_t          tst_q, tst_d;
    logic [IW-1:0]    tidx_q, tidx_d;
    logic [PW-1:0]    snap_q, snap_d;
    logic [RCW-1:0]   refr_q, refr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tst_q <= T_IDLE; tidx_q <= '0; snap_q <= '0; refr_q <= '0;
        end else begin
            tst_q <= tst_d; tidx_q <= tidx_d; snap_q <= snap_d; refr_q <= refr_d;
        end
    end

    always_comb begin
        tx_sum = '0;
        for (int i = 0; i < N_BYTES; i++) tx_sum = tx_sum + snap_q[8*i +: 8];
    end

    // Frames are built from the snapshot, so data_in may change freely mid-frame.
    always_comb begin
        tst_d = tst_q; tidx_d = tidx_q; snap_d = snap_q; refr_d = refr_q;
        wr_uart = 1'b0; w_data = SYNC_BYTE;
        case (tst_q)
            T_IDLE: begin
                if (data_in != snap_q || refr_q == RCW'(REFRESH_CYC - 1)) begin
                    tst_d = T_SYNC; snap_d = data_in; refr_d = '0;
                end else refr_d = refr_q + 1'b1;
            end
            T_SYNC: if (!tx_full) begin wr_uart = 1'b1; tst_d = T_DATA; tidx_d = '0; end
            T_DATA: begin
                w_data = snap_q[8*tidx_q +: 8];
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    if (tidx_q == IW'(N_BYTES - 1)) tst_d = T_CSUM;
                    else tidx_d = tidx_q + 1'b1;
                end
            end
            T_CSUM: begin
                w_data = tx_sum;
                if (!tx_full) begin wr_uart = 1'b1; tst_d = T_IDLE; end
            end
            default: tst_d = T_IDLE;
        endcase
    end

    rstate_t          rst_q, rst_d;
    logic [IW-1:0]    ridx_q, ridx_d;
    logic [7:0]       sum_q, sum_d;
    logic [PW-1:0]    shad_q, shad_d, dout_q, dout_d;
    logic [BTW-1:0]   tmo_q, tmo_d;
    logic [LTW-1:0]   ltmr_q, ltmr_d;
    logic             vld_q, vld_d, link_q, link_d, bump_err;
    logic [ERR_W-1:0] err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q <= R_HUNT; ridx_q <= '0; sum_q <= '0; shad_q <= '0; dout_q <= '0;
            tmo_q <= '0; ltmr_q <= '0; vld_q <= 1'b0; link_q <= 1'b0; err_q <= '0;
        end else begin
            rst_q <= rst_d; ridx_q <= ridx_d; sum_q <= sum_d; shad_q <= shad_d; dout_q <= dout_d;
            tmo_q <= tmo_d; ltmr_q <= ltmr_d; vld_q <= vld_d; link_q <= link_d; err_q <= err_d;
        end
    end

    always_comb begin
        rst_d = rst_q; ridx_d = ridx_q; sum_d = sum_q; shad_d = shad_q; dout_d = dout_q;
        tmo_d = tmo_q; ltmr_d = ltmr_q; vld_d = 1'b0; link_d = link_q; err_d = err_q;
        bump_err = 1'b0;
        if (ltmr_q == LTW'(LINK_TMO - 1)) link_d = 1'b0;
        else ltmr_d = ltmr_q + 1'b1;
        if (rd_uart) begin
            case (rst_q)
                R_HUNT: if (r_data == SYNC_BYTE) begin
                    rst_d = R_DATA; ridx_d = '0; sum_d = '0; tmo_d = '0;
                end
                R_DATA: begin
                    shad_d[8*ridx_q +: 8] = r_data;
                    sum_d = sum_q + r_data;
                    tmo_d = '0;
                    if (ridx_q == IW'(N_BYTES - 1)) rst_d = R_CSUM;
                    else ridx_d = ridx_q + 1'b1;
                end
                R_CSUM: begin
                    if (r_data == sum_q) begin
                        dout_d = shad_q; vld_d = 1'b1; ltmr_d = '0; link_d = 1'b1;
                    end else bump_err = 1'b1;
                    rst_d = R_HUNT;
                end
                default: rst_d = R_HUNT;
            endcase
        end else if (rst_q != R_HUNT) begin
            if (tmo_q == BTW'(BYTE_TMO - 1)) begin
                bump_err = 1'b1; rst_d = R_HUNT; shad_d = '0;
            end else tmo_d = tmo_q + 1'b1;
        end
        if (bump_err && err_q != '1) err_d = err_q + 1'b1;
    end

    assign tx       = tx_q;
    assign data_out = dout_q;
    assign rx_valid = vld_q;
    assign link_up  = link_q;
    assign tx_busy  = (tst_q != T_IDLE);
    assign err_cnt  = err_q;
endmodule

// File: tb/tb_uart_frame_link.sv
// Bench for uart_frame_link: loopback and injected serial frames checked against a frame-level model.
module tb_uart_frame_link;
    localparam int NB = 2, RC = 4000, BT = 600, LT = 8000, BITC = 32;

    logic        clk = 1'b0, rst = 1'b1, loop = 1'b0, rx_drv = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        tx, rx_valid, link_up, tx_busy, rx_w;
    logic [15:0] data_out;
    logic [7:0]  err_cnt;
    int          n_chk = 0, n_fail = 0, cyc = 0, vld_cnt = 0, last_vld = 0, err_exp = 0;
    logic [15:0] dout_exp = 16'h0000;
    logic [7:0]  txq[$];

    assign rx_w = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_frame_link #(.N_BYTES(NB), .DVSR(1), .DVSR_BIT(2), .FIFO_W(2), .SYNC_BYTE(8'hA5),
        .REFRESH_CYC(RC), .BYTE_TMO(BT), .LINK_TMO(LT), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .rx(rx_w), .data_in(data_in), .tx(tx), .data_out(data_out),
        .rx_valid(rx_valid), .link_up(link_up), .tx_busy(tx_busy), .err_cnt(err_cnt));

    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin vld_cnt++; last_vld = cyc; end
    end

    // Serial decoder on tx: sample each bit at its middle (32 clk cycles per bit).
    initial forever begin
        logic [7:0] b;
        @(negedge tx);
        repeat (48) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 b[i] = tx;
            if (i < 7) repeat (BITC) @(posedge clk);
        end
        txq.push_back(b);
        repeat (24) @(posedge clk);
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, got %0d cycles want < 95000", cyc);
        $fatal(1);
    end

    function automatic logic [7:0] model_csum(input logic [15:0] p);
        int s = 0;
        for (int i = 0; i < NB; i++) s += (p >> (8 * i)) & 255;
        return 8'(s % 256);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) rx_drv = f[i];
            repeat (BITC - 1) @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] p, input logic corrupt);
        logic [7:0] c;
        c = model_csum(p);
        if (corrupt) c = c ^ 8'($urandom_range(1, 255));
        send_byte(8'hA5); send_byte(p[7:0]); send_byte(p[15:8]); send_byte(c);
    endtask

    task automatic wait_busy(input logic lvl, input int lim, output int t);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (tx_busy !== lvl && n < lim);
        t = cyc;
        n_chk++; if (tx_busy !== lvl) begin n_fail++; $display("FAIL wait_tx_busy: got %b want %b within %0d cycles", tx_busy, lvl, lim); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) @(posedge clk); #1;
        n_chk++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_chk++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        n_chk++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_chk++; if (link_up !== 1'b0) begin n_fail++; $display("FAIL reset_link_up: got %b want 0", link_up); end
        n_chk++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        n_chk++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_loop_frame(input logic [15:0] p, input int win);
        logic [7:0] exp_b[4];
        int v0;
        exp_b = '{8'hA5, p[7:0], p[15:8], model_csum(p)};
        loop = 1'b1;
        @(negedge clk);
        txq.delete(); v0 = vld_cnt; data_in = p; dout_exp = p;
        repeat (win) @(posedge clk); #1;
        n_chk++; if (txq.size() != 4) begin n_fail++; $display("FAIL loop_tx_count: got %0d want 4", txq.size()); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (i >= txq.size() || txq[i] !== exp_b[i]) begin
                n_fail++; $display("FAIL loop_tx_byte%0d: got %h want %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp_b[i]);
            end
        end
        n_chk++; if (data_out !== dout_exp) begin n_fail++; $display("FAIL loop_data_out: got %h want %h", data_out, dout_exp); end
        n_chk++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL loop_rx_valid_pulses: got %0d want 1", vld_cnt - v0); end
        n_chk++; if (link_up !== 1'b1) begin n_fail++; $display("FAIL loop_link_up: got %b want 1", link_up); end
        n_chk++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL loop_err_cnt: got %0d want %0d", err_cnt, err_exp); end
    endtask

    task automatic test_refresh_and_link;
        int k1, m, k2, v0, n, tf;
        wait_busy(1'b1, 6000, k1);
        v0 = vld_cnt;
        wait_busy(1'b0, 100, m);
        wait_busy(1'b1, RC + 200, k2);
        n_chk++; if (k2 - m != RC) begin n_fail++; $display("FAIL refresh_idle_cycles: got %0d want %0d", k2 - m, RC); end
        n_chk++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL refresh_frames_per_period: got %0d want 1", vld_cnt - v0); end
        wait_busy(1'b0, 100, m);
        repeat (1500) @(posedge clk); #1;
        n_chk++; if (data_out !== dout_exp) begin n_fail++; $display("FAIL refresh_data_out: got %h want %h", data_out, dout_exp); end
        n_chk++; if (link_up !== 1'b1) begin n_fail++; $display("FAIL link_before_drop: got %b want 1", link_up); end
        @(negedge clk) loop = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (link_up !== 1'b0 && n < LT + 2000);
        tf = cyc - last_vld;
        n_chk++; if (tf < LT - 2 || tf > LT + 2) begin n_fail++; $display("FAIL link_drop_delay: got %0d want %0d", tf, LT); end
    endtask

    task automatic test_bad_csum;
        int v0;
        v0 = vld_cnt;
        send_byte(8'hA5); send_byte(8'h34); send_byte(8'h12); send_byte(8'h47);
        err_exp++;
        repeat (20) @(posedge clk); #1;
        n_chk++; if (data_out !== dout_exp) begin n_fail++; $display("FAIL badcs_data_out: got %h want %h", data_out, dout_exp); end
        n_chk++; if (vld_cnt != v0) begin n_fail++; $display("FAIL badcs_rx_valid: got %0d pulses want 0", vld_cnt - v0); end
        n_chk++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL badcs_err_cnt: got %0d want %0d", err_cnt, err_exp); end
    endtask

    task automatic test_byte_timeout;
        int v0;
        send_byte(8'hA5); send_byte(8'h34);
        repeat (BT + 300) @(posedge clk); #1;
        err_exp++;
        n_chk++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL tmo_err_cnt: got %0d want %0d", err_cnt, err_exp); end
        v0 = vld_cnt;
        send_byte(8'hA5); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h78);
        dout_exp = 16'hABCD;
        repeat (20) @(posedge clk); #1;
        n_chk++; if (data_out !== dout_exp) begin n_fail++; $display("FAIL tmo_next_data_out: got %h want %h", data_out, dout_exp); end
        n_chk++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL tmo_next_rx_valid: got %0d want 1", vld_cnt - v0); end
        n_chk++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL tmo_next_err_cnt: got %0d want %0d", err_cnt, err_exp); end
    endtask

    task automatic test_random_frames;
        logic [15:0] p;
        logic [7:0]  j;
        logic        bad;
        int          v0, vexp;
        for (int k = 0; k < 8; k++) begin
            p = 16'($urandom);
            if (k == 2) p = {8'hA5, p[7:0]};
            bad = ($urandom_range(0, 2) == 0);
            v0 = vld_cnt;
            if ($urandom_range(0, 1) == 1) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h5A;
                send_byte(j);
            end
            send_frame(p, bad);
            if (bad) begin err_exp++; vexp = 0; end
            else begin dout_exp = p; vexp = 1; end
            repeat (20) @(posedge clk); #1;
            n_chk++; if (data_out !== dout_exp) begin n_fail++; $display("FAIL rand%0d_data_out: got %h want %h", k, data_out, dout_exp); end
            n_chk++; if (vld_cnt - v0 != vexp) begin n_fail++; $display("FAIL rand%0d_rx_valid: got %0d want %0d", k, vld_cnt - v0, vexp); end
            n_chk++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL rand%0d_err_cnt: got %0d want %0d", k, err_cnt, err_exp); end
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] p;
        int v0;
        @(negedge clk) data_in = 16'h5A3C;
        send_byte(8'hA5); send_byte(8'h11);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_chk++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b want 1", tx); end
        n_chk++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL midrst_data_out: got %h want 0", data_out); end
        n_chk++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rx_valid: got %b want 0", rx_valid); end
        n_chk++; if (link_up !== 1'b0) begin n_fail++; $display("FAIL midrst_link_up: got %b want 0", link_up); end
        n_chk++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_busy: got %b want 0", tx_busy); end
        n_chk++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL midrst_err_cnt: got %0d want 0", err_cnt); end
        @(negedge clk) rst = 1'b0;
        err_exp = 0;
        p = 16'($urandom);
        v0 = vld_cnt;
        send_frame(p, 1'b0);
        dout_exp = p;
        repeat (20) @(posedge clk); #1;
        n_chk++; if (data_out !== dout_exp) begin n_fail++; $display("FAIL postrst_data_out: got %h want %h", data_out, dout_exp); end
        n_chk++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL postrst_rx_valid: got %0d want 1", vld_cnt - v0); end
        n_chk++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL postrst_err_cnt: got %0d want %0d", err_cnt, err_exp); end
        n_chk++; if (link_up !== 1'b1) begin n_fail++; $display("FAIL postrst_link_up: got %b want 1", link_up); end
    endtask

    initial begin
        test_reset();
        test_loop_frame(16'h1234, 3000);
        test_loop_frame(16'hA5A5, 2500);
        test_refresh_and_link();
        test_bad_csum();
        test_byte_timeout();
        test_random_frames();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
